// File: rtl/mux_chk_pkg.sv
// Shared types, code constants and protocol helper functions for the
// traffic/dice multiplexer result checker and its benches.
package mux_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNPRIMED = 2'd0,
    ST_TRAFFIC  = 2'd1,
    ST_DICE     = 2'd2
  } chk_state_t;

  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] RED_AMBER = 3'b110;
  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] AMBER     = 3'b010;

  localparam logic [2:0] DICE_MIN = 3'b001;
  localparam logic [2:0] DICE_MAX = 3'b110;

  localparam logic [2:0] CAUSE_NONE        = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL     = 3'd1;
  localparam logic [2:0] CAUSE_TRAFFIC_SEQ = 3'd2;
  localparam logic [2:0] CAUSE_DICE_HOLD   = 3'd3;
  localparam logic [2:0] CAUSE_DICE_STEP   = 3'd4;

  // mode: 1 = traffic, 0 = dice
  function automatic logic code_legal(input logic mode, input logic [2:0] code);
    if (mode)
      return (code == RED) || (code == RED_AMBER) || (code == GREEN) || (code == AMBER);
    else
      return (code >= DICE_MIN) && (code <= DICE_MAX);
  endfunction

  function automatic logic [2:0] next_traffic(input logic [2:0] code);
    case (code)
      RED:       return RED_AMBER;
      RED_AMBER: return GREEN;
      GREEN:     return AMBER;
      default:   return RED;
    endcase
  endfunction

  function automatic logic [2:0] next_dice(input logic [2:0] code);
    return (code == DICE_MAX) ? DICE_MIN : code + 3'd1;
  endfunction

endpackage

// File: rtl/mux_result_checker_sat_counter.sv
// Increment-enable counter that holds at all-ones; synchronous active-high reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/mux_result_checker.sv
// Protocol monitor for the traffic/dice multiplexer output. Inputs are captured
// into a sample stage, checked against the held previous sample, and errors registered one edge later.
module mux_result_checker
  import mux_chk_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               button,
  input  logic [2:0]         result,
  output logic               err_pulse,
  output logic               err_sticky,
  output logic [2:0]         err_cause,
  output logic [COUNT_W-1:0] err_count,
  output logic               primed
);

  chk_state_t state, state_nxt;

  logic       samp_vld;
  logic       samp_sel;
  logic       samp_button;
  logic [2:0] samp_result;

  logic [2:0] prev_result, prev_nxt;
  logic       prev_button;

  logic       viol;
  logic [2:0] cause_nxt;
  logic       mode_change;

  // The registered mode is implied by the state itself.
  assign mode_change = ((state == ST_TRAFFIC) && !samp_sel) ||
                       ((state == ST_DICE)    &&  samp_sel);

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev_result;
    viol      = 1'b0;
    cause_nxt = CAUSE_NONE;
    if (samp_vld) begin
      if (!code_legal(samp_sel, samp_result)) begin
        viol      = 1'b1;
        cause_nxt = CAUSE_ILLEGAL;
        state_nxt = ST_UNPRIMED;
      end else begin
        prev_nxt = samp_result;
        if (state == ST_UNPRIMED) begin
          state_nxt = samp_sel ? ST_TRAFFIC : ST_DICE;
        end else if (mode_change) begin
          // No sequence relation exists across a mode switch; re-prime.
          state_nxt = ST_UNPRIMED;
        end else if (state == ST_TRAFFIC) begin
          if (samp_result != next_traffic(prev_result)) begin
            viol      = 1'b1;
            cause_nxt = CAUSE_TRAFFIC_SEQ;
          end
        end else if (prev_button) begin
          if (samp_result != next_dice(prev_result)) begin
            viol      = 1'b1;
            cause_nxt = CAUSE_DICE_STEP;
          end
        end else if (samp_result != prev_result) begin
          viol      = 1'b1;
          cause_nxt = CAUSE_DICE_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_UNPRIMED;
      samp_vld    <= 1'b0;
      samp_sel    <= 1'b0;
      samp_button <= 1'b0;
      samp_result <= 3'd0;
      prev_result <= 3'd0;
      prev_button <= 1'b0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      err_cause   <= CAUSE_NONE;
    end else begin
      samp_vld    <= 1'b1;
      samp_sel    <= sel;
      samp_button <= button;
      samp_result <= result;
      state       <= state_nxt;
      prev_result <= prev_nxt;
      if (samp_vld)
        prev_button <= samp_button;
      err_pulse   <= viol;
      err_sticky  <= err_sticky | viol;
      if (viol)
        err_cause <= cause_nxt;
    end
  end

  assign primed = (state != ST_UNPRIMED);

  sat_counter #(.W(COUNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (viol),
    .count (err_count)
  );

endmodule

// File: tb/tb_mux_result_checker.sv
// Directed bench for mux_result_checker; a second instance with a 2-bit counter covers saturation.
module tb_mux_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       button = 1'b0;
  logic [2:0] result = 3'd0;

  logic       err_pulse, err_sticky, primed;
  logic [2:0] err_cause;
  logic [7:0] err_count;

  logic       err_pulse2, err_sticky2, primed2;
  logic [2:0] err_cause2;
  logic [1:0] err_count2;

  int checks = 0;
  int failures = 0;
  int pulses;

  always #5 clk = ~clk;

  mux_result_checker #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cause(err_cause),
    .err_count(err_count), .primed(primed)
  );

  mux_result_checker #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .err_pulse(err_pulse2), .err_sticky(err_sticky2), .err_cause(err_cause2),
    .err_count(err_count2), .primed(primed2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample, let the edge take it, then settle before sampling outputs.
  task automatic drive(input logic s, input logic b, input logic [2:0] r);
    sel = s; button = b; result = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 3'b000);
    check("rst_pulse",  err_pulse,  0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cause",  err_cause,  0);
    check("rst_count",  err_count,  0);
    check("rst_primed", primed,     0);
    rst = 1'b0;

    // Traffic clean run
    drive(1'b1, 1'b0, 3'b100);
    check("trf_primed_early", primed, 0);
    drive(1'b1, 1'b0, 3'b110);
    check("trf_primed", primed, 1);
    drive(1'b1, 1'b0, 3'b001);
    drive(1'b1, 1'b0, 3'b010);
    drive(1'b1, 1'b0, 3'b100);
    drive(1'b1, 1'b0, 3'b110);
    drive(1'b1, 1'b0, 3'b001);
    check("trf_clean_count",  err_count,  0);
    check("trf_clean_sticky", err_sticky, 0);
    check("trf_clean_primed", primed,     1);

    // Traffic skip 110 -> 010
    do_reset();
    drive(1'b1, 1'b0, 3'b100);
    drive(1'b1, 1'b0, 3'b110);
    drive(1'b1, 1'b0, 3'b010);
    check("skip_no_pulse_yet", err_pulse, 0);
    drive(1'b1, 1'b0, 3'b100);
    check("skip_pulse",  err_pulse,  1);
    check("skip_cause",  err_cause,  2);
    check("skip_count",  err_count,  1);
    check("skip_sticky", err_sticky, 1);
    drive(1'b1, 1'b0, 3'b110);
    check("skip_pulse_once", err_pulse, 0);
    check("skip_count_hold", err_count, 1);

    // Dice step with wrap, then hold violation
    do_reset();
    drive(1'b0, 1'b1, 3'b101);
    drive(1'b0, 1'b1, 3'b110);
    drive(1'b0, 1'b0, 3'b001);
    drive(1'b0, 1'b0, 3'b011);
    check("dice_wrap_count", err_count, 0);
    check("dice_wrap_pulse", err_pulse, 0);
    drive(1'b0, 1'b0, 3'b011);
    check("dice_hold_pulse", err_pulse, 1);
    check("dice_hold_cause", err_cause, 3);
    check("dice_hold_count", err_count, 1);

    // Dice step violation: button high but value held
    do_reset();
    drive(1'b0, 1'b1, 3'b011);
    drive(1'b0, 1'b0, 3'b011);
    drive(1'b0, 1'b0, 3'b011);
    check("dice_step_cause", err_cause, 4);
    check("dice_step_pulse", err_pulse, 1);

    // Illegal code, then re-prime
    do_reset();
    drive(1'b0, 1'b0, 3'b010);
    drive(1'b0, 1'b0, 3'b111);
    check("ill_primed_before", primed, 1);
    drive(1'b0, 1'b0, 3'b100);
    check("ill_pulse",  err_pulse, 1);
    check("ill_cause",  err_cause, 1);
    check("ill_primed", primed,    0);
    drive(1'b0, 1'b0, 3'b100);
    check("ill_reprime",    primed,    1);
    check("ill_reprime_ok", err_pulse, 0);
    drive(1'b0, 1'b0, 3'b100);
    check("ill_count", err_count, 1);

    // Mode switch, then reset mid-stream
    do_reset();
    drive(1'b1, 1'b0, 3'b100);
    drive(1'b1, 1'b0, 3'b110);
    drive(1'b1, 1'b0, 3'b001);
    drive(1'b0, 1'b0, 3'b100);
    drive(1'b0, 1'b0, 3'b111);
    check("mode_pulse",  err_pulse, 0);
    check("mode_count",  err_count, 0);
    check("mode_primed", primed,    0);
    drive(1'b0, 1'b0, 3'b100);
    check("mode_ill_sticky", err_sticky, 1);
    check("mode_ill_cause",  err_cause,  1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b100);
    check("mid_rst_pulse",  err_pulse,  0);
    check("mid_rst_sticky", err_sticky, 0);
    check("mid_rst_cause",  err_cause,  0);
    check("mid_rst_count",  err_count,  0);
    check("mid_rst_primed", primed,     0);
    rst = 1'b0;

    // Saturation: five illegal dice codes
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b0, 1'b0, 3'b111);
      else       drive(1'b0, 1'b0, 3'b001);
      if (err_pulse2) pulses++;
    end
    check("sat_pulses",     pulses,     5);
    check("sat_count2",     err_count2, 3);
    check("sat_count8",     err_count,  5);
    drive(1'b0, 1'b0, 3'b111);
    drive(1'b0, 1'b0, 3'b001);
    check("sat_count2_hold", err_count2, 3);
    check("sat_sticky2",     err_sticky2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_result_checker.md
# mux_result_checker

Synthesizable run-time monitor that sits on the `result` output of the traffic-light/dice multiplexer and checks every sampled value against the protocol that multiplexer is meant to produce. It is the consuming end of that interface. It watches `sel`, `button` and `result`, tracks the expected next value, and flags illegal codes or illegal transitions through a sticky error flag, a one-cycle error pulse, a cause code and a saturating error counter. It is instantiated beside the multiplexer in the top level and is also used as an embedded checker in benches.

## Interface
- COUNT_W, 8, width of the error counter
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset; the same net that resets the multiplexer
- sel  input  1  mode of the observed stream: 1 = traffic, 0 = dice
- button  input  1  dice roll request, as driven into the multiplexer
- result  input  3  observed multiplexer output
- err_pulse  output  1  high for exactly one cycle per detected violation
- err_sticky  output  1  set on first violation, cleared only by rst
- err_cause  output  3  cause of the most recent violation: 0 none, 1 illegal code, 2 traffic sequence, 3 dice hold, 4 dice step
- err_count  output  COUNT_W  number of violations, saturating at all-ones
- primed  output  1  high when a valid previous sample is held and sequence checks are active

## Operation
- Legal traffic codes: 100 red, 110 red-amber, 001 green, 010 amber. The sequence is 100→110→001→010→100. Repeating the same code is illegal.
- Legal dice codes: 001–110. When `button` was 1 on the previous sample, the next value is prev+1, with 110 wrapping to 001. When `button` was 0, the value must equal prev.
- The FSM has three states: UNPRIMED, TRAFFIC, DICE.
  - UNPRIMED: the next sample is only legality-checked. If it is legal, store it and go to TRAFFIC or DICE according to `sel`. If it is illegal, raise cause 1 and stay UNPRIMED.
  - TRAFFIC / DICE: each sample is checked for legality first (cause 1). A legal sample is then checked against the sequence (cause 2, 3 or 4). The previous sample is always overwritten with the current legal `result`.
  - An illegal sample returns the FSM to UNPRIMED, so that one bad value produces exactly one error.
- Mode change: if `sel` differs from the registered `sel`, the sample is treated as in UNPRIMED. There is no sequence check across a mode switch.
- Only one cause is reported per sample. Legality has priority over sequence.
- `err_count` increments with `err_pulse` and holds at 2^COUNT_W−1.

## Timing
- Inputs are sampled on each rising edge of `clk`.
- A violation in the sample taken at edge N drives `err_pulse`, `err_cause` and the `err_count` update after edge N+1 (registered, latency 1).
- `button` is registered together with `result`. The step check at edge N uses the `button` value sampled at edge N−1.
- Reset values (set by `rst` high at an edge): state UNPRIMED, `primed` 0, `err_pulse` 0, `err_sticky` 0, `err_cause` 0, `err_count` 0, and all stored samples 0.
- While `rst` is high, no checks run. The first sample taken at the first edge with `rst` low is an UNPRIMED sample.
- Reset asserted mid-sequence clears all state within the same edge. Errors already reported are not preserved.
- `primed` rises in the cycle after the first legal sample. It falls in the cycle after an illegal sample or a mode change.

## Structure
- Package `mux_chk_pkg` holds:
  - the FSM state enum;
  - the traffic code constants RED, RED_AMBER, GREEN, AMBER;
  - DICE_MIN = 3'b001 and DICE_MAX = 3'b110;
  - the err_cause constants.
- One natural sub-module, `sat_counter`: a parameterised width, increment-enable counter with synchronous reset that saturates at all-ones. It implements `err_count`.
- The next-value and legality functions live in the package, shared with the bench.

## Test plan
- Traffic clean run: rst 1 for 2 cycles, then `sel`=1 with `result` 100,110,001,010,100,110 → `err_count` 0, `primed` 1 from the second post-reset cycle.
- Traffic skip: sequence 100,110,010 → one `err_pulse` the cycle after 010 is sampled, `err_cause` 2, `err_count` 1, `err_sticky` 1.
- Dice step with wrap: `sel`=0, `button`=1 every cycle, `result` 101,110,001 → no error. Then `button`=0 and `result` changes 001→011 → `err_cause` 3.
- Illegal code: dice stream 010 then 111 → `err_cause` 1, `primed` drops. The next value 100 re-primes with no error.
- Mode switch and reset: traffic at 001, `sel`→0 with `result` 100 → no error. Assert `rst` for one cycle mid-stream → all outputs return to 0 on the next edge.
- Saturation with COUNT_W=2: inject 5 illegal codes → `err_count` reads 3 and stays at 3, with 5 `err_pulse` cycles.
